// File: rtl/axi4_write_region_pkg.sv
// Shared types and constants for the AXI4 write-side region decoder.
package axi4_write_region_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD_AW,
        FWD_W,
        FWD_B,
        ERR_W,
        ERR_B
    } write_region_state_t;

    localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR_C = 2'b11;

endpackage

// File: rtl/axi4_addr_region_lookup.sv
// Combinational address-to-region priority match. Lowest matching index wins.
// Kept standalone so the read-side decoder can share it.
module axi4_addr_region_lookup
    import axi4_write_region_pkg::*;
#(
    parameter int ADDR_WIDTH_P    = 32,
    parameter int NR_OF_REGIONS_P = 1,
    parameter logic [NR_OF_REGIONS_P-1:0][ADDR_WIDTH_P-1:0] REGION_BASE_P = '0,
    parameter logic [NR_OF_REGIONS_P-1:0][ADDR_WIDTH_P-1:0] REGION_MASK_P = '0
)(
    input  logic [ADDR_WIDTH_P-1:0] i_addr,
    output logic                    o_hit,
    output logic [3:0]              o_region
);

    // Scan from the top index down so the lowest hitting region is left last.
    always_comb begin
        o_hit    = 1'b0;
        o_region = 4'd0;
        for (int i = NR_OF_REGIONS_P - 1; i >= 0; i--) begin
            if ((i_addr & REGION_MASK_P[i]) == REGION_BASE_P[i]) begin
                o_hit    = 1'b1;
                o_region = 4'(i);
            end
        end
    end

endmodule

// File: rtl/axi4_write_region_decoder.sv
// AXI4 write front end: decodes AW against a region map, forwards mapped
// bursts with awregion, terminates unmapped bursts locally with DECERR.
// One outstanding transaction at a time.
module axi4_write_region_decoder
    import axi4_write_region_pkg::*;
#(
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int AXI_ADDR_WIDTH_P = 32,
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_STRB_WIDTH_P = 4,
    parameter int NR_OF_REGIONS_P  = 1,
    parameter logic [NR_OF_REGIONS_P-1:0][AXI_ADDR_WIDTH_P-1:0] REGION_BASE_P = '0,
    parameter logic [NR_OF_REGIONS_P-1:0][AXI_ADDR_WIDTH_P-1:0] REGION_MASK_P = '0
)(
    input  logic                        i_clk,
    input  logic                        i_rst,
    // master AW
    input  logic [AXI_ID_WIDTH_P-1:0]   i_mst_awid,
    input  logic [AXI_ADDR_WIDTH_P-1:0] i_mst_awaddr,
    input  logic [7:0]                  i_mst_awlen,
    input  logic [2:0]                  i_mst_awsize,
    input  logic [1:0]                  i_mst_awburst,
    input  logic                        i_mst_awvalid,
    output logic                        o_mst_awready,
    // master W
    input  logic [AXI_DATA_WIDTH_P-1:0] i_mst_wdata,
    input  logic [AXI_STRB_WIDTH_P-1:0] i_mst_wstrb,
    input  logic                        i_mst_wlast,
    input  logic                        i_mst_wvalid,
    output logic                        o_mst_wready,
    // master B
    output logic [AXI_ID_WIDTH_P-1:0]   o_mst_bid,
    output logic [1:0]                  o_mst_bresp,
    output logic                        o_mst_bvalid,
    input  logic                        i_mst_bready,
    // slave AW
    output logic [AXI_ID_WIDTH_P-1:0]   o_slv_awid,
    output logic [AXI_ADDR_WIDTH_P-1:0] o_slv_awaddr,
    output logic [7:0]                  o_slv_awlen,
    output logic [2:0]                  o_slv_awsize,
    output logic [1:0]                  o_slv_awburst,
    output logic [3:0]                  o_slv_awregion,
    output logic                        o_slv_awvalid,
    input  logic                        i_slv_awready,
    // slave W
    output logic [AXI_DATA_WIDTH_P-1:0] o_slv_wdata,
    output logic [AXI_STRB_WIDTH_P-1:0] o_slv_wstrb,
    output logic                        o_slv_wlast,
    output logic                        o_slv_wvalid,
    input  logic                        i_slv_wready,
    // slave B
    input  logic [AXI_ID_WIDTH_P-1:0]   i_slv_bid,
    input  logic [1:0]                  i_slv_bresp,
    input  logic                        i_slv_bvalid,
    output logic                        o_slv_bready,
    // status
    output logic [15:0]                 o_decerr_cnt,
    output logic                        o_wlast_err
);

    write_region_state_t r_state, w_state_nxt;

    logic                        r_init_done;
    logic [AXI_ID_WIDTH_P-1:0]   r_awid;
    logic [AXI_ADDR_WIDTH_P-1:0] r_awaddr;
    logic [7:0]                  r_awlen;
    logic [2:0]                  r_awsize;
    logic [1:0]                  r_awburst;
    logic [3:0]                  r_awregion;
    logic [7:0]                  r_beat_cnt;
    logic [15:0]                 r_decerr_cnt;
    logic                        r_wlast_err;

    logic       w_hit;
    logic [3:0] w_region;
    logic       w_aw_hs;
    logic       w_fwd_w_hs;

    axi4_addr_region_lookup #(
        .ADDR_WIDTH_P    (AXI_ADDR_WIDTH_P),
        .NR_OF_REGIONS_P (NR_OF_REGIONS_P),
        .REGION_BASE_P   (REGION_BASE_P),
        .REGION_MASK_P   (REGION_MASK_P)
    ) u_lookup (
        .i_addr   (i_mst_awaddr),
        .o_hit    (w_hit),
        .o_region (w_region)
    );

    // awready is only offered in IDLE after the first post-reset cycle.
    assign w_aw_hs    = (r_state == IDLE) && r_init_done && i_mst_awvalid;
    assign w_fwd_w_hs = (r_state == FWD_W) && i_mst_wvalid && i_slv_wready;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; W phases follow wlast even if the beat count disagrees.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_aw_hs) w_state_nxt = w_hit ? FWD_AW : ERR_W;
            FWD_AW:  if (i_slv_awready) w_state_nxt = FWD_W;
            FWD_W:   if (w_fwd_w_hs && i_mst_wlast) w_state_nxt = FWD_B;
            FWD_B:   if (i_slv_bvalid && i_mst_bready) w_state_nxt = IDLE;
            ERR_W:   if (i_mst_wvalid && i_mst_wlast) w_state_nxt = ERR_B;
            ERR_B:   if (i_mst_bready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-state handshake and pass-through muxing; everything idles at zero.
    always_comb begin
        o_mst_awready = 1'b0;
        o_mst_wready  = 1'b0;
        o_slv_wvalid  = 1'b0;
        o_slv_wdata   = '0;
        o_slv_wstrb   = '0;
        o_slv_wlast   = 1'b0;
        o_mst_bvalid  = 1'b0;
        o_mst_bid     = '0;
        o_mst_bresp   = AXI_RESP_OKAY_C;
        o_slv_bready  = 1'b0;
        case (r_state)
            IDLE:  o_mst_awready = r_init_done;
            FWD_W: begin
                o_mst_wready = i_slv_wready;
                o_slv_wvalid = i_mst_wvalid;
                o_slv_wdata  = i_mst_wdata;
                o_slv_wstrb  = i_mst_wstrb;
                o_slv_wlast  = i_mst_wlast;
            end
            FWD_B: begin
                o_mst_bvalid = i_slv_bvalid;
                o_mst_bid    = i_slv_bid;
                o_mst_bresp  = i_slv_bresp;
                o_slv_bready = i_mst_bready;
            end
            ERR_W: o_mst_wready = 1'b1;
            ERR_B: begin
                o_mst_bvalid = 1'b1;
                o_mst_bid    = r_awid;
                o_mst_bresp  = AXI_RESP_DECERR_C;
            end
            default: ;
        endcase
    end

    // Hold awready low for one cycle after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_init_done <= 1'b0;
        else       r_init_done <= 1'b1;
    end

    // Capture AW fields and decoded region; slave AW is driven only from here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_awsize   <= '0;
            r_awburst  <= '0;
            r_awregion <= '0;
        end else if (w_aw_hs) begin
            r_awid     <= i_mst_awid;
            r_awaddr   <= i_mst_awaddr;
            r_awlen    <= i_mst_awlen;
            r_awsize   <= i_mst_awsize;
            r_awburst  <= i_mst_awburst;
            r_awregion <= w_region;
        end
    end

    // Beat counter: flag any beat whose wlast disagrees with its position vs awlen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beat_cnt  <= '0;
            r_wlast_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_beat_cnt <= '0;
        end else if (w_fwd_w_hs) begin
            if (i_mst_wlast != (r_beat_cnt == r_awlen)) r_wlast_err <= 1'b1;
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Count unmapped bursts on entry to ERR_W, saturating.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_decerr_cnt <= '0;
        else if (w_aw_hs && !w_hit && (r_decerr_cnt != 16'hFFFF))
            r_decerr_cnt <= r_decerr_cnt + 16'd1;
    end

    assign o_slv_awid     = r_awid;
    assign o_slv_awaddr   = r_awaddr;
    assign o_slv_awlen    = r_awlen;
    assign o_slv_awsize   = r_awsize;
    assign o_slv_awburst  = r_awburst;
    assign o_slv_awregion = r_awregion;
    assign o_slv_awvalid  = (r_state == FWD_AW);
    assign o_decerr_cnt   = r_decerr_cnt;
    assign o_wlast_err    = r_wlast_err;

endmodule

// File: tb/tb_axi4_write_region_decoder.sv
// Scoreboard bench for axi4_write_region_decoder: directed bursts push expected
// slave AW/W and master B items; a negedge monitor pops and compares them.
module tb_axi4_write_region_decoder;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int NR  = 4;
    // r0 0x0xxx_xxxx, r1 0x1xxx_xxxx, r2 0x4xxx_xxxx, r3 0x4..0x7 (overlaps r2)
    localparam logic [NR-1:0][AW-1:0] BASE = {32'h4000_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NR-1:0][AW-1:0] MASK = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  region;
    } aw_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic clk, rst;
    logic [IDW-1:0] mst_awid;   logic [AW-1:0] mst_awaddr; logic [7:0] mst_awlen;
    logic [2:0] mst_awsize;     logic [1:0] mst_awburst;   logic mst_awvalid, mst_awready;
    logic [DW-1:0] mst_wdata;   logic [SW-1:0] mst_wstrb;  logic mst_wlast, mst_wvalid, mst_wready;
    logic [IDW-1:0] mst_bid;    logic [1:0] mst_bresp;     logic mst_bvalid, mst_bready;
    logic [IDW-1:0] slv_awid;   logic [AW-1:0] slv_awaddr; logic [7:0] slv_awlen;
    logic [2:0] slv_awsize;     logic [1:0] slv_awburst;   logic [3:0] slv_awregion;
    logic slv_awvalid, slv_awready;
    logic [DW-1:0] slv_wdata;   logic [SW-1:0] slv_wstrb;  logic slv_wlast, slv_wvalid, slv_wready;
    logic [IDW-1:0] slv_bid;    logic [1:0] slv_bresp;     logic slv_bvalid, slv_bready;
    logic [15:0] decerr_cnt;    logic wlast_err;

    int n_tests = 0;
    int n_fail  = 0;
    aw_t q_aw[$];
    w_t  q_w[$];
    b_t  q_b[$];

    axi4_write_region_decoder #(
        .AXI_ID_WIDTH_P(IDW), .AXI_ADDR_WIDTH_P(AW), .AXI_DATA_WIDTH_P(DW),
        .AXI_STRB_WIDTH_P(SW), .NR_OF_REGIONS_P(NR),
        .REGION_BASE_P(BASE), .REGION_MASK_P(MASK)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mst_awid(mst_awid), .i_mst_awaddr(mst_awaddr), .i_mst_awlen(mst_awlen),
        .i_mst_awsize(mst_awsize), .i_mst_awburst(mst_awburst),
        .i_mst_awvalid(mst_awvalid), .o_mst_awready(mst_awready),
        .i_mst_wdata(mst_wdata), .i_mst_wstrb(mst_wstrb), .i_mst_wlast(mst_wlast),
        .i_mst_wvalid(mst_wvalid), .o_mst_wready(mst_wready),
        .o_mst_bid(mst_bid), .o_mst_bresp(mst_bresp), .o_mst_bvalid(mst_bvalid),
        .i_mst_bready(mst_bready),
        .o_slv_awid(slv_awid), .o_slv_awaddr(slv_awaddr), .o_slv_awlen(slv_awlen),
        .o_slv_awsize(slv_awsize), .o_slv_awburst(slv_awburst), .o_slv_awregion(slv_awregion),
        .o_slv_awvalid(slv_awvalid), .i_slv_awready(slv_awready),
        .o_slv_wdata(slv_wdata), .o_slv_wstrb(slv_wstrb), .o_slv_wlast(slv_wlast),
        .o_slv_wvalid(slv_wvalid), .i_slv_wready(slv_wready),
        .i_slv_bid(slv_bid), .i_slv_bresp(slv_bresp), .i_slv_bvalid(slv_bvalid),
        .o_slv_bready(slv_bready),
        .o_decerr_cnt(decerr_cnt), .o_wlast_err(wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every handshake the DUT presents.
    initial begin : monitor
        aw_t ga;
        w_t  gw;
        b_t  gb;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (slv_awvalid && slv_awready) begin
                    ga = '{slv_awid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awregion};
                    if (q_aw.size() == 0) chk("slv_aw_unexpected", 64'(ga), 64'd0);
                    else chk("slv_aw", 64'(ga), 64'(q_aw.pop_front()));
                end
                if (slv_wvalid && slv_wready) begin
                    gw = '{slv_wdata, slv_wstrb, slv_wlast};
                    if (q_w.size() == 0) chk("slv_w_unexpected", 64'(gw), 64'd0);
                    else chk("slv_w", 64'(gw), 64'(q_w.pop_front()));
                end
                if (mst_bvalid && mst_bready) begin
                    gb = '{mst_bid, mst_bresp};
                    if (q_b.size() == 0) chk("mst_b_unexpected", 64'(gb), 64'd0);
                    else chk("mst_b", 64'(gb), 64'(q_b.pop_front()));
                end
            end
        end
    end

    // Slave model: one-cycle awready stall, alternating wready, OKAY B after wlast.
    initial begin : slave
        logic awv, aw_hs, wl_hs, b_hs;
        logic [3:0] sid;
        slv_awready = 1'b0; slv_wready = 1'b0; slv_bvalid = 1'b0;
        slv_bid = '0; slv_bresp = 2'b00; sid = '0;
        forever begin
            @(negedge clk);
            awv   = slv_awvalid;
            aw_hs = slv_awvalid && slv_awready;
            wl_hs = slv_wvalid && slv_wready && slv_wlast;
            b_hs  = slv_bvalid && slv_bready;
            if (aw_hs) sid = slv_awid;
            @(posedge clk); #1;
            if (rst) begin
                slv_awready = 1'b0; slv_wready = 1'b0; slv_bvalid = 1'b0;
            end else begin
                slv_awready = awv && !aw_hs;
                slv_wready  = !slv_wready;
                if (b_hs) slv_bvalid = 1'b0;
                if (wl_hs) begin
                    slv_bvalid = 1'b1; slv_bid = sid; slv_bresp = 2'b00;
                end
            end
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit fwd, input logic [3:0] rgn);
        int k;
        @(posedge clk); #1;
        mst_awid = id; mst_awaddr = addr; mst_awlen = len;
        mst_awsize = 3'd2; mst_awburst = 2'd1; mst_awvalid = 1'b1;
        if (fwd) q_aw.push_back('{id, addr, len, 3'd2, 2'd1, rgn});
        k = 0;
        do begin @(negedge clk); k++; end while (!mst_awready && k < 100);
        if (!mst_awready) chk("aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 mst_awvalid = 1'b0;
        @(negedge clk);
        chk("slv_awvalid_next_cycle", 64'(slv_awvalid), 64'(fwd));
        if (fwd) chk("slv_awregion", 64'(slv_awregion), 64'(rgn));
    endtask

    task automatic send_w(input int n, input int last_idx, input bit fwd, input logic [31:0] seed);
        int k;
        @(posedge clk); #1;
        for (int b = 0; b < n; b++) begin
            mst_wdata = seed + 32'(b); mst_wstrb = 4'(b + 1);
            mst_wlast = (b == last_idx); mst_wvalid = 1'b1;
            if (fwd) q_w.push_back('{mst_wdata, mst_wstrb, mst_wlast});
            k = 0;
            do begin
                @(negedge clk); k++;
                if (!fwd) chk("err_slv_wvalid_low", 64'(slv_wvalid), 64'd0);
            end while (!mst_wready && k < 100);
            if (!mst_wready) chk("w_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        mst_wvalid = 1'b0; mst_wlast = 1'b0;
    endtask

    // Wait for the master B handshake; optional latency check; then the next
    // cycle must already offer awready (back-to-back).
    task automatic wait_b(input int exp_lat);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!(mst_bvalid && mst_bready) && k < 200);
        if (!(mst_bvalid && mst_bready)) chk("b_timeout", 64'd0, 64'd1);
        else if (exp_lat > 0) chk("err_b_latency", 64'(k), 64'(exp_lat));
        @(negedge clk);
        chk("awready_after_b", 64'(mst_awready), 64'd1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1;
        mst_awid = '0; mst_awaddr = '0; mst_awlen = '0; mst_awsize = '0; mst_awburst = '0;
        mst_awvalid = 1'b0; mst_wdata = '0; mst_wstrb = '0; mst_wlast = 1'b0; mst_wvalid = 1'b0;
        mst_bready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_awready", 64'(mst_awready), 64'd0);
        chk("rst_slv_awvalid", 64'(slv_awvalid), 64'd0);
        chk("rst_bvalid", 64'(mst_bvalid), 64'd0);
        chk("rst_decerr_cnt", 64'(decerr_cnt), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("awready_release_cycle0", 64'(mst_awready), 64'd0);
        @(negedge clk); chk("awready_release_cycle1", 64'(mst_awready), 64'd1);

        // Mapped to region 1, 4 beats, id 3
        send_aw(4'd3, 32'h1000_0040, 8'd3, 1'b1, 4'd1);
        q_b.push_back('{4'd3, 2'b00});
        send_w(4, 3, 1'b1, 32'hA000_0000);
        wait_b(0);

        // Unmapped, 8 beats sunk, DECERR one cycle after wlast
        send_aw(4'd5, 32'h8000_0000, 8'd7, 1'b0, 4'd0);
        q_b.push_back('{4'd5, 2'b11});
        send_w(8, 7, 1'b0, 32'hB000_0000);
        wait_b(1);
        chk("decerr_cnt_1", 64'(decerr_cnt), 64'd1);

        // Overlap: regions 2 and 3 both match, lower wins; then only region 3
        send_aw(4'd9, 32'h4000_1000, 8'd0, 1'b1, 4'd2);
        q_b.push_back('{4'd9, 2'b00});
        send_w(1, 0, 1'b1, 32'hC000_0000);
        wait_b(0);
        send_aw(4'd10, 32'h5000_0000, 8'd1, 1'b1, 4'd3);
        q_b.push_back('{4'd10, 2'b00});
        send_w(2, 1, 1'b1, 32'hC100_0000);
        wait_b(0);
        chk("wlast_err_clean", 64'(wlast_err), 64'd0);

        // Early wlast: len 3 but wlast on the third beat
        send_aw(4'd1, 32'h0000_0100, 8'd3, 1'b1, 4'd0);
        q_b.push_back('{4'd1, 2'b00});
        send_w(3, 2, 1'b1, 32'hD000_0000);
        wait_b(0);
        chk("wlast_err_set", 64'(wlast_err), 64'd1);

        // W presented before AW: must stall, then pass intact
        @(posedge clk); #1;
        mst_wdata = 32'hE000_0000; mst_wstrb = 4'd1; mst_wlast = 1'b0; mst_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("w_before_aw_stall", 64'(mst_wready), 64'd0);
        end
        send_aw(4'd6, 32'h1000_0200, 8'd1, 1'b1, 4'd1);
        q_b.push_back('{4'd6, 2'b00});
        send_w(2, 1, 1'b1, 32'hE000_0000);
        wait_b(0);
        chk("wlast_err_sticky", 64'(wlast_err), 64'd1);

        // Reset in the middle of a forwarded burst
        send_aw(4'd2, 32'h1000_0300, 8'd3, 1'b1, 4'd1);
        send_w(2, -1, 1'b1, 32'hF000_0000);
        mst_wvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_awready", 64'(mst_awready), 64'd0);
        chk("midrst_wready", 64'(mst_wready), 64'd0);
        chk("midrst_slv_wvalid", 64'(slv_wvalid), 64'd0);
        chk("midrst_slv_awvalid", 64'(slv_awvalid), 64'd0);
        chk("midrst_slv_awaddr", 64'(slv_awaddr), 64'd0);
        chk("midrst_bvalid", 64'(mst_bvalid), 64'd0);
        chk("midrst_decerr_cnt", 64'(decerr_cnt), 64'd0);
        chk("midrst_wlast_err", 64'(wlast_err), 64'd0);
        mst_wvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("midrst_awready_c0", 64'(mst_awready), 64'd0);
        @(negedge clk); chk("midrst_awready_c1", 64'(mst_awready), 64'd1);

        send_aw(4'd7, 32'h1000_0080, 8'd1, 1'b1, 4'd1);
        q_b.push_back('{4'd7, 2'b00});
        send_w(2, 1, 1'b1, 32'h1234_0000);
        wait_b(0);
        chk("post_rst_wlast_err", 64'(wlast_err), 64'd0);

        repeat (3) @(negedge clk);
        chk("q_aw_drained", 64'(q_aw.size()), 64'd0);
        chk("q_w_drained", 64'(q_w.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
